// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory access sequencer.
//   - SZ_BYTE / SZ_HALF / SZ_WORD: req_val size encodings (2'b11 is illegal)
//   - dmem_state_t: sequencer FSM states
//   - DEF_MEM_LO_WORD / DEF_MEM_HI_WORD: default valid word-index range
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] DEF_MEM_LO_WORD = 32'h0000_0c00;
  localparam logic [31:0] DEF_MEM_HI_WORD = 32'h0003_bffe;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP,
    ST_ERR
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_merge.sv
// dmem_lane_merge: combinational lane handling for the access sequencer.
//   rbuf        in  32  word read from memory
//   rs2         in  32  right-justified store data
//   size        in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   lane        in  2   byte address bits [1:0]
//   is_unsigned in  1   zero-extend sub-word loads
//   wdata       out 32  rbuf with the addressed lane replaced by rs2
//   rdata       out 32  addressed lane of rbuf, sign/zero extended
// Half accesses use lane[1] only (lane[0] ignored); word accesses ignore lane.
module dmem_lane_merge
  import dmem_pkg::*;
(
  input  logic [31:0] rbuf,
  input  logic [31:0] rs2,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [4:0]  sh;
  logic [31:0] shifted;

  always_comb begin
    sh      = '0;
    shifted = '0;
    wdata   = rbuf;
    rdata   = '0;
    case (size)
      SZ_BYTE: begin
        sh      = {lane, 3'b000};
        shifted = rbuf >> sh;
        wdata   = (rbuf & ~(32'h0000_00ff << sh)) | ({24'h0, rs2[7:0]} << sh);
        rdata   = is_unsigned ? {24'h0, shifted[7:0]}
                              : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        sh      = {lane[1], 4'b0000};
        shifted = rbuf >> sh;
        wdata   = (rbuf & ~(32'h0000_ffff << sh)) | ({16'h0, rs2[15:0]} << sh);
        rdata   = is_unsigned ? {16'h0, shifted[15:0]}
                              : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        wdata = rs2;
        rdata = rbuf;
      end
      default: begin
        wdata = rbuf;
        rdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequencer between the load/store stage and a word-only
// data memory. Byte/half/word requests over valid/ready; sub-word stores are
// read-modify-write; loads are sign/zero extended; bad requests get resp_err.
//   clock, reset       clock, synchronous active-high reset
//   req_valid/ready    request handshake (ready only in IDLE)
//   req_addr           byte address
//   req_rw             0 load, 1 store
//   req_val            size: 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned       zero-extend sub-word loads
//   rs2                right-justified store data
//   resp_valid/ready   response handshake
//   resp_err           request rejected
//   rdata              extended load data (0 for stores and errors)
//   mem_addr           word-aligned memory address
//   mem_rw             memory write strobe (only in WR)
//   mem_wdata          full merged write word
//   mem_rdata          combinational memory read data
// Build option: DMEM_ALIGN_CHECK_EN defined rejects misaligned half/word
// requests; undefined, half uses addr & ~1 and word uses addr & ~3.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] MEM_LO_WORD = DEF_MEM_LO_WORD,
  parameter logic [31:0] MEM_HI_WORD = DEF_MEM_HI_WORD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_rw,
  input  logic [1:0]  req_val,
  input  logic        req_unsigned,
  input  logic [31:0] rs2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rw,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  dmem_state_t state;

  // The word part of the latched address lives in mem_addr; only the lane
  // bits need a separate latch.
  logic [1:0]  lane_q;
  logic        rw_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] rs2_q;

  logic [31:0] word_idx;
  logic        in_range;
  logic        misalign;
  logic        req_bad;
  logic [31:0] merged_wdata;
  logic [31:0] load_data;

  assign word_idx = {2'b00, req_addr[31:2]};
  assign in_range = (word_idx >= MEM_LO_WORD) && (word_idx <= MEM_HI_WORD);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = ((req_val == SZ_HALF) && req_addr[0]) ||
                    ((req_val == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_bad = (req_val == 2'b11) || misalign || !in_range;

  // rbuf is taken straight from mem_rdata during RD: the merged word and the
  // extended load value are registered on the RD edge, which is exactly when
  // a separate rbuf register would have captured it.
  dmem_lane_merge u_lane_merge (
    .rbuf        (mem_rdata),
    .rs2         (rs2_q),
    .size        (size_q),
    .lane        (lane_q),
    .is_unsigned (uns_q),
    .wdata       (merged_wdata),
    .rdata       (load_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_rw     <= 1'b0;
      mem_wdata  <= '0;
      lane_q     <= '0;
      rw_q       <= 1'b0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      rs2_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            lane_q    <= req_addr[1:0];
            rw_q      <= req_rw;
            size_q    <= req_val;
            uns_q     <= req_unsigned;
            rs2_q     <= rs2;
            req_ready <= 1'b0;
            rdata     <= '0;
            if (req_bad) begin
              state      <= ST_ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_rw && (req_val == SZ_WORD)) begin
              state     <= ST_WR;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= rs2;
              mem_rw    <= 1'b1;
            end else begin
              state    <= ST_RD;
              mem_addr <= {req_addr[31:2], 2'b00};
            end
          end
        end
        ST_RD: begin
          if (rw_q) begin
            state     <= ST_WR;
            mem_wdata <= merged_wdata;
            mem_rw    <= 1'b1;
          end else begin
            state      <= ST_RESP;
            rdata      <= load_data;
            resp_valid <= 1'b1;
          end
        end
        ST_WR: begin
          state      <= ST_RESP;
          mem_rw     <= 1'b0;
          resp_valid <= 1'b1;
        end
        ST_RESP, ST_ERR: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rdata      <= '0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          mem_rw <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: self-checking bench for dmem_access_ctrl. A byte-level
// reference memory predicts load values, error decisions, write words and
// latencies; a word array behind the memory port plays the real memory.
module tb_dmem_access_ctrl;

  localparam logic [31:0] LO_WORD = 32'h0000_0c00;
  localparam logic [31:0] HI_WORD = 32'h0003_bffe;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_rw;
  logic [1:0]  req_val;
  logic        req_unsigned;
  logic [31:0] rs2;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic        mem_rw;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] tbmem [0:255];
  logic [7:0]  refb [logic [31:0]];

  always #5 clock = ~clock;

  dmem_access_ctrl #(
    .MEM_LO_WORD (32'h0000_0c00),
    .MEM_HI_WORD (32'h0003_bffe)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_rw       (req_rw),
    .req_val      (req_val),
    .req_unsigned (req_unsigned),
    .rs2          (rs2),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_err     (resp_err),
    .rdata        (rdata),
    .mem_addr     (mem_addr),
    .mem_rw       (mem_rw),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Memory: tests keep all touched words at distinct mem_addr[9:2] slots.
  assign mem_rdata = tbmem[mem_addr[9:2]];
  always @(posedge clock) if (mem_rw) tbmem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] rb(input logic [31:0] a);
    return refb.exists(a) ? refb[a] : 8'h00;
  endfunction

  function automatic logic [31:0] eff_addr(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return a;
    if (sz == 2'd1) return a & 32'hFFFF_FFFE;
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] widx;
    logic e;
    widx = a / 4;
    e = (sz == 2'd3) || (widx < LO_WORD) || (widx > HI_WORD);
`ifdef DMEM_ALIGN_CHECK_EN
    if (sz == 2'd1 && (a % 2) != 0) e = 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] ea, v;
    ea = eff_addr(a, sz);
    v = 0;
    for (int unsigned i = 0; i < nbytes(sz); i++) v = v + ({24'h0, rb(ea + i)} << (8 * i));
    if (!uns && sz == 2'd0 && v >= 32'h80) v = v + 32'hFFFF_FF00;
    if (!uns && sz == 2'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] ea, t;
    ea = eff_addr(a, sz);
    for (int unsigned i = 0; i < nbytes(sz); i++) begin
      t = d >> (8 * i);
      refb[ea + i] = t[7:0];
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] wa);
    return {rb(wa + 3), rb(wa + 2), rb(wa + 1), rb(wa)};
  endfunction

  // ---------------- one transaction ----------------
  task automatic do_req(input logic [31:0] a, input logic rw, input logic [1:0] sz,
                        input logic uns, input logic [31:0] d, input int unsigned hold,
                        output logic [31:0] got_rd, output logic [31:0] got_wd);
    logic e;
    logic [31:0] exp_rd, exp_wd, exp_ma;
    int unsigned exp_lat, wr_cnt, cyc;
    e = model_err(a, sz);
    exp_ma = a & 32'hFFFF_FFFC;
    exp_rd = '0;
    exp_wd = '0;
    if (!e) begin
      if (rw) begin
        model_store(a, sz, d);
        exp_wd = model_word(exp_ma);
      end else begin
        exp_rd = model_load(a, sz, uns);
      end
    end
    exp_lat = e ? 1 : (!rw ? 2 : (sz == 2'd2 ? 2 : 3));

    @(negedge clock);
    req_valid = 1'b1; req_addr = a; req_rw = rw; req_val = sz;
    req_unsigned = uns; rs2 = d; resp_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    cyc = 0; wr_cnt = 0; got_wd = '0;
    while (resp_valid !== 1'b1 && cyc < 20) begin
      if (mem_rw === 1'b1) begin
        wr_cnt++;
        got_wd = mem_wdata;
        chk("wr_wdata", mem_wdata, exp_wd);
      end
      if (!e) chk("busy_mem_addr", mem_addr, exp_ma);
      chk("busy_req_ready", {31'h0, req_ready}, 32'd0);
      @(posedge clock); #1;
      cyc++;
    end
    chk("latency", cyc + 1, exp_lat);
    chk("wr_cycles", wr_cnt, (rw && !e) ? 32'd1 : 32'd0);
    got_rd = rdata;
    for (int unsigned h = 0; h <= hold; h++) begin
      if (h != 0) begin @(posedge clock); #1; end
      chk("resp_valid", {31'h0, resp_valid}, 32'd1);
      chk("resp_err", {31'h0, resp_err}, {31'h0, e});
      chk("rdata", rdata, exp_rd);
      chk("hold_req_ready", {31'h0, req_ready}, 32'd0);
      chk("hold_mem_rw", {31'h0, mem_rw}, 32'd0);
    end
    @(negedge clock);
    resp_ready = 1'b1;
    @(posedge clock); #1;
    chk("after_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("after_req_ready", {31'h0, req_ready}, 32'd1);
    @(negedge clock);
    resp_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'd1);
    chk({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'd0);
    chk({tag, "_resp_err"}, {31'h0, resp_err}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_mem_rw"}, {31'h0, mem_rw}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    logic [31:0] rd, wd, a, d, w;
    logic [1:0]  sz;
    int unsigned r;

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_rw = 1'b0;
    req_val = '0; req_unsigned = 1'b0; rs2 = '0; resp_ready = 1'b0;

    for (int unsigned i = 0; i < 256; i++) tbmem[i] = 32'h0;
    for (int unsigned i = 0; i < 64; i++) begin
      w = $urandom;
      tbmem[i] = w;
      for (int unsigned b = 0; b < 4; b++) begin
        d = w >> (8 * b);
        refb[32'h3000 + 4 * i + b] = d[7:0];
      end
    end

    repeat (3) @(posedge clock);
    #1;
    chk_reset_vals("reset");
    @(negedge clock);
    reset = 1'b0;

    // Word store then word load.
    do_req(32'h3000, 1'b1, 2'd2, 1'b0, 32'h1234_5678, 0, rd, wd);
    chk("tp_word_store_wdata", wd, 32'h1234_5678);
    do_req(32'h3000, 1'b0, 2'd2, 1'b0, 32'h0, 0, rd, wd);
    chk("tp_word_load", rd, 32'h1234_5678);

    // Byte store read-modify-write.
    do_req(32'h3002, 1'b1, 2'd0, 1'b0, 32'hFFFF_FFAB, 0, rd, wd);
    chk("tp_byte_store_wdata", wd, 32'h12AB_5678);
    do_req(32'h3002, 1'b0, 2'd0, 1'b0, 32'h0, 0, rd, wd);
    chk("tp_lb_signed", rd, 32'hFFFF_FFAB);
    do_req(32'h3002, 1'b0, 2'd0, 1'b1, 32'h0, 0, rd, wd);
    chk("tp_lbu", rd, 32'h0000_00AB);

    // Misaligned half load.
    do_req(32'h3001, 1'b0, 2'd1, 1'b0, 32'h0, 0, rd, wd);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("tp_misalign_half", rd, 32'h0);
`else
    chk("tp_misalign_half", rd, 32'h0000_5678);
`endif

    // Range and size errors, including both range edges.
    do_req(32'h0000_0000, 1'b0, 2'd2, 1'b0, 32'h0, 0, rd, wd);
    do_req(32'h3004, 1'b0, 2'd3, 1'b0, 32'h0, 0, rd, wd);
    do_req(32'h2FFC, 1'b1, 2'd2, 1'b0, 32'hCAFE_0001, 0, rd, wd);
    do_req(32'h000E_FFF8, 1'b1, 2'd2, 1'b0, 32'hCAFE_0002, 0, rd, wd);
    chk("tp_hi_edge_wdata", wd, 32'hCAFE_0002);
    do_req(32'h000E_FFFC, 1'b1, 2'd2, 1'b0, 32'hCAFE_0003, 0, rd, wd);

    // Response held for 5 cycles.
    do_req(32'h3010, 1'b1, 2'd1, 1'b0, 32'h0000_BEEF, 5, rd, wd);
    do_req(32'h3010, 1'b0, 2'd1, 1'b0, 32'h0, 5, rd, wd);

    // Reset while in RD of a byte store: no write, outputs back to reset.
    @(negedge clock);
    req_valid = 1'b1; req_addr = 32'h3005; req_rw = 1'b1; req_val = 2'd0;
    req_unsigned = 1'b0; rs2 = 32'h55;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("rd_mem_rw", {31'h0, mem_rw}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk_reset_vals("midreset");
    @(negedge clock);
    reset = 1'b0;
    do_req(32'h3005, 1'b0, 2'd0, 1'b1, 32'h0, 0, rd, wd);

    // Random traffic.
    for (int unsigned n = 0; n < 150; n++) begin
      r = $urandom_range(0, 15);
      a = (r == 0) ? 32'($urandom_range(0, 32'h2FFF)) : 32'h3000 + 32'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      sz = (r == 9) ? 2'd3 : 2'(r % 3);
      do_req(a, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom,
             $urandom_range(0, 3), rd, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
